// File: rtl/led_ser_pkg.sv
// Shared types and defaults for the LED serial link receiver.
// Holds the receiver state enum, default widths and the counter width helper.
package led_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        FULL
    } state_e;

    localparam int DEF_BIT_WIDTH   = 16;
    localparam int DEF_SYNC_STAGES = 2;

    // Counter must hold 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchronizer with rising-edge detect for one asynchronous input.
// Ports: clk, rstn (sync, active-low), d (async in), q_sync (synced level),
//        rise (high one cycle when q_sync goes 0->1).
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/led_serial_rx.sv
// Serial-to-parallel receiver for the LED link: shifts LSB-first bits into
// the MSB and commits the word on a latch rise.
// Ports: clk, rstn (sync, active-low), ser_clk/ser_dat/ser_lat (async in),
//        par_out (committed word), valid/frame_err/ovf (1-cycle pulses),
//        busy (partial frame in progress). All outputs registered.
module led_serial_rx
    import led_ser_pkg::*;
#(
    parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ser_clk,
    input  logic                 ser_dat,
    input  logic                 ser_lat,
    output logic [BIT_WIDTH-1:0] par_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 ovf,
    output logic                 busy
);

    localparam int CW = cnt_width(BIT_WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(BIT_WIDTH);

    logic clk_rise;
    logic lat_rise;
    logic dat_s;
    logic clk_s_unused;
    logic lat_s_unused;
    logic dat_rise_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk (
        .clk    (clk),
        .rstn   (rstn),
        .d      (ser_clk),
        .q_sync (clk_s_unused),
        .rise   (clk_rise)
    );

    // Data rides the same synchronizer depth as the clock, so the level
    // seen on a clock rise is the one sampled alongside it.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dat (
        .clk    (clk),
        .rstn   (rstn),
        .d      (ser_dat),
        .q_sync (dat_s),
        .rise   (dat_rise_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lat (
        .clk    (clk),
        .rstn   (rstn),
        .d      (ser_lat),
        .q_sync (lat_s_unused),
        .rise   (lat_rise)
    );

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 extra_q, extra_d;
    logic [BIT_WIDTH-1:0] sh_q, sh_d;
    logic [BIT_WIDTH-1:0] par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            extra_q <= 1'b0;
            sh_q    <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            extra_q <= extra_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        extra_d = extra_q;
        sh_d    = sh_q;
        par_d   = par_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        ovf_d   = 1'b0;

        // Bit is taken first so a coincident latch sees it.
        if (clk_rise) begin
            sh_d = {dat_s, sh_q[BIT_WIDTH-1:1]};
            if (cnt_q == CNT_MAX) begin
                extra_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (clk_rise) begin
                    state_d = (cnt_d == CNT_MAX) ? FULL : RECV;
                end
            end
            RECV: begin
                if (cnt_d == CNT_MAX) begin
                    state_d = FULL;
                end
            end
            FULL:    state_d = FULL;
            default: state_d = IDLE;
        endcase

        if (lat_rise) begin
            if (cnt_d == CNT_MAX) begin
                par_d   = sh_d;
                valid_d = 1'b1;
                ovf_d   = extra_d;
            end else if (cnt_d != '0) begin
                ferr_d = 1'b1;
            end
            cnt_d   = '0;
            extra_d = 1'b0;
            state_d = IDLE;
        end

        busy_d = (state_d == RECV);
    end

    assign par_out   = par_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_led_serial_rx.sv
// Directed bench for led_serial_rx: frames, short/long frames, reset,
// coincident clock/latch and held latch, with pulse counting.
module tb_led_serial_rx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ser_clk = 1'b0;
    logic        ser_dat = 1'b0;
    logic        ser_lat = 1'b0;
    logic [15:0] par_out;
    logic        valid;
    logic        frame_err;
    logic        ovf;
    logic        busy;

    int tests = 0;
    int fails = 0;

    int n_valid = 0;
    int n_ferr = 0;
    int n_ovf = 0;
    int n_both = 0;

    int s_valid, s_ferr, s_ovf, s_both;

    led_serial_rx #(.BIT_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ser_clk   (ser_clk),
        .ser_dat   (ser_dat),
        .ser_lat   (ser_lat),
        .par_out   (par_out),
        .valid     (valid),
        .frame_err (frame_err),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_valid += int'(valid);
        n_ferr  += int'(frame_err);
        n_ovf   += int'(ovf);
        n_both  += int'(valid & ovf);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ser_dat = b;
        wait_cyc(4);
        ser_clk = 1'b1;
        wait_cyc(4);
        ser_clk = 1'b0;
        wait_cyc(4);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic latch();
        @(negedge clk);
        ser_lat = 1'b1;
        wait_cyc(4);
        ser_lat = 1'b0;
        wait_cyc(6);
    endtask

    task automatic snap();
        s_valid = n_valid;
        s_ferr  = n_ferr;
        s_ovf   = n_ovf;
        s_both  = n_both;
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_par", 32'(par_out), 32'h0);
        chk("rst_flags", {28'h0, valid, frame_err, ovf, busy}, 32'h0);
        rstn = 1'b1;
        wait_cyc(3);

        // Frame 0xA5C3 with exact latency check on valid.
        snap();
        send_bits(32'hA5C3, 8);
        chk("t1_busy_mid", 32'(busy), 32'h1);
        send_bits(32'h00A5, 8);
        chk("t1_busy_full", 32'(busy), 32'h0);
        @(negedge clk);
        ser_lat = 1'b1;
        @(negedge clk);
        chk("t1_valid_c1", 32'(valid), 32'h0);
        @(negedge clk);
        chk("t1_valid_c2", 32'(valid), 32'h0);
        @(negedge clk);
        chk("t1_valid_c3", 32'(valid), 32'h1);
        chk("t1_par", 32'(par_out), 32'hA5C3);
        chk("t1_ovf", 32'(ovf), 32'h0);
        @(negedge clk);
        chk("t1_valid_c4", 32'(valid), 32'h0);
        ser_lat = 1'b0;
        wait_cyc(6);
        chk("t1_nvalid", 32'(n_valid - s_valid), 32'd1);
        chk("t1_nferr", 32'(n_ferr - s_ferr), 32'd0);
        chk("t1_novf", 32'(n_ovf - s_ovf), 32'd0);

        // Short frame: 10 bits.
        snap();
        send_bits(32'h3FF, 10);
        chk("t2_busy", 32'(busy), 32'h1);
        latch();
        chk("t2_nferr", 32'(n_ferr - s_ferr), 32'd1);
        chk("t2_nvalid", 32'(n_valid - s_valid), 32'd0);
        chk("t2_par", 32'(par_out), 32'hA5C3);
        chk("t2_busy_after", 32'(busy), 32'h0);

        // Long frame: 4 junk bits then 0x1234.
        snap();
        send_bits(32'hD, 4);
        send_bits(32'h1234, 16);
        latch();
        chk("t3_par", 32'(par_out), 32'h1234);
        chk("t3_nvalid", 32'(n_valid - s_valid), 32'd1);
        chk("t3_novf", 32'(n_ovf - s_ovf), 32'd1);
        chk("t3_nboth", 32'(n_both - s_both), 32'd1);
        chk("t3_nferr", 32'(n_ferr - s_ferr), 32'd0);

        // Reset mid-frame, then a full 0x00FF frame.
        snap();
        send_bits(32'h55, 8);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("t4_rst_par", 32'(par_out), 32'h0);
        chk("t4_rst_flags", {28'h0, valid, frame_err, ovf, busy}, 32'h0);
        wait_cyc(3);
        send_bits(32'h00FF, 16);
        latch();
        chk("t4_par", 32'(par_out), 32'h00FF);
        chk("t4_nferr", 32'(n_ferr - s_ferr), 32'd0);
        chk("t4_nvalid", 32'(n_valid - s_valid), 32'd1);

        // 16th clock rise coincides with latch rise.
        snap();
        send_bits(32'hC0DE, 15);
        @(negedge clk);
        ser_dat = 1'b1;
        wait_cyc(4);
        ser_clk = 1'b1;
        ser_lat = 1'b1;
        wait_cyc(4);
        ser_clk = 1'b0;
        ser_lat = 1'b0;
        wait_cyc(6);
        chk("t5_par", 32'(par_out), 32'hC0DE);
        chk("t5_nvalid", 32'(n_valid - s_valid), 32'd1);
        chk("t5_nferr", 32'(n_ferr - s_ferr), 32'd0);

        // Latch with no bits, then latch held high.
        snap();
        latch();
        @(negedge clk);
        ser_lat = 1'b1;
        wait_cyc(50);
        chk("t6_busy_held", 32'(busy), 32'h0);
        ser_lat = 1'b0;
        wait_cyc(6);
        chk("t6_npulses",
            32'((n_valid - s_valid) + (n_ferr - s_ferr) + (n_ovf - s_ovf)),
            32'd0);
        chk("t6_par", 32'(par_out), 32'hC0DE);
        chk("t6_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_serial_rx.md
Name: led_serial_rx

Overview:
Serial-to-parallel receiver for the LED serial link. It is the far end of the LED shift-out chain: it accepts a serial clock, data and latch from the LED shifter/driver and reconstructs the parallel LED word. Each frame is sent LSB first, shifted right into the MSB, and committed on the latch pulse. It serves as a loopback checker on-board and as the LED model in simulation.

Parameters:
BIT_WIDTH, 16, LED word width; number of bits per frame.
SYNC_STAGES, 2, synchronizer flops on each serial input; minimum 2.

Ports:
clk  input  1  system clock; all logic on posedge.
rstn  input  1  synchronous, active-low reset.
ser_clk  input  1  serial shift clock, asynchronous to clk; data is valid on its rising edge.
ser_dat  input  1  serial data; LSB of the word is sent first.
ser_lat  input  1  latch; a rising edge commits the frame.
par_out  output  BIT_WIDTH  last committed LED word.
valid  output  1  one-cycle pulse when par_out updates.
frame_err  output  1  one-cycle pulse when a latch arrives with fewer than BIT_WIDTH bits.
ovf  output  1  one-cycle pulse with valid when more than BIT_WIDTH bits preceded the latch.
busy  output  1  high while a frame is partially received (bit count 1..BIT_WIDTH-1).

Behaviour:
- Reset (rstn=0 at posedge clk): par_out=0, valid=0, frame_err=0, ovf=0, busy=0. The shift register, bit counter and synchronizer/edge flops clear to 0. This applies mid-frame too: the partial frame is discarded and there is no error pulse.
- Input path:
  - Each input passes through SYNC_STAGES flops plus one previous-value flop.
  - A rising edge is detected when sync=1 and prev=0.
  - ser_dat is delayed to stay aligned with the ser_clk edge detect.
  - Latency from a pin edge to the internal event is SYNC_STAGES+1 clk cycles.
- Shift on a ser_clk rise: sh <= {dat_s, sh[BIT_WIDTH-1:1]}. After BIT_WIDTH bits, sh[0] holds the first bit received.
- Counter: cnt saturates at BIT_WIDTH. A sticky extra flag is set if a bit arrives while cnt==BIT_WIDTH. Shifting continues, so the last BIT_WIDTH bits win (chain semantics).
- FSM states:
  - IDLE (cnt=0): a ser_clk rise goes to RECV.
  - RECV (0<cnt<BIT_WIDTH): the bit that makes cnt==BIT_WIDTH goes to FULL.
  - FULL: further bits set extra.
  - Any state: a ser_lat rise returns to IDLE, clearing cnt and extra.
- On a latch event:
  - cnt==BIT_WIDTH: par_out <= sh and valid=1 next cycle; ovf=1 on the same cycle if extra.
  - cnt<BIT_WIDTH with cnt>0: frame_err=1; par_out and sh are unchanged.
  - cnt==0: nothing happens and no pulse is generated.
- Simultaneous ser_clk and ser_lat events in the same cycle: the bit is shifted and counted first, then the latch evaluates the updated sh/cnt in that same cycle.
- A held high ser_lat or ser_clk produces one event only (edge-triggered).
- busy = (state==RECV). It is a registered output, and all outputs are registered.

Decomposition:
- Package led_ser_pkg holds:
  - the state enum (IDLE, RECV, FULL);
  - default BIT_WIDTH and SYNC_STAGES localparams;
  - the counter width function clog2(BIT_WIDTH+1).
- Sub-module sync_edge (parameter SYNC_STAGES; ports clk, rstn, d, q_sync, rise) is instantiated for ser_clk, ser_dat and ser_lat. The rise output is left unused for ser_dat.

Test Plan:
- 16 bits of 0xA5C3 LSB-first, then latch -> par_out=0xA5C3; one valid pulse SYNC_STAGES+1 cycles after the latch edge; frame_err=0, ovf=0.
- 10 bits then latch -> frame_err pulses once; par_out holds its prior value 0xA5C3; valid=0.
- 20 bits (4 junk bits, then 0x1234 LSB-first) then latch -> par_out=0x1234; valid=1 and ovf=1 on the same cycle.
- rstn=0 for one cycle after 8 bits, then a full 0x00FF frame and latch -> par_out=0x00FF; no frame_err at any point; all outputs 0 during the cycle after reset.
- 16th ser_clk rise coincides with the ser_lat rise -> frame committed with the 16th bit included; valid=1, frame_err=0.
- Latch with no bits, and ser_lat held high for 50 cycles -> no pulses, par_out unchanged, busy=0.
